// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        DONE
    } state_t;

    localparam int unsigned PAT_W_DEFAULT = 4;
    localparam logic [PAT_W_DEFAULT-1:0] DEFAULT_PATTERN = 4'b1010;

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, MSB-first shift register; zeros are shifted in behind the data
// so the serial line idles low once the pattern has been sent.
module seq_piso
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] data,
    output logic             serial_bit,
    output logic             last_bit
);

    localparam int unsigned IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    logic [PAT_W-1:0] shreg;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
            idx   <= '0;
        end else if (load) begin
            shreg <= data;
            idx   <= '0;
        end else if (shift) begin
            shreg <= {shreg[PAT_W-2:0], 1'b0};
            // Index parks on the LSB position instead of wrapping.
            idx   <= (idx == LAST_IDX) ? idx : idx + 1'b1;
        end
    end

    assign serial_bit = shreg[PAT_W-1];
    assign last_bit   = (idx == LAST_IDX);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: repeats a latched pattern MSB-first with an
// optional idle gap between repetitions.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEFAULT,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_cycles,
    input  logic             abort,
    output logic             output_bit,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] reps_sent
);

    state_t           state;
    logic [PAT_W-1:0] pat_lat;
    logic [CNT_W-1:0] rep_lat;
    logic [GAP_W-1:0] gap_lat;
    logic [GAP_W-1:0] gap_cnt;

    logic             piso_load;
    logic             piso_shift;
    logic [PAT_W-1:0] piso_data;
    logic             piso_last;

    logic [CNT_W:0]   reps_inc;
    logic             more_reps;

    always_comb begin
        reps_inc  = {1'b0, reps_sent} + {{CNT_W{1'b0}}, 1'b1};
        more_reps = (reps_inc < {1'b0, rep_lat});
    end

    // The shifter's MSB register is the serial output; loading zeros on abort
    // keeps output_bit registered while forcing it low in the next cycle.
    always_comb begin
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        piso_data  = pat_lat;
        if (abort) begin
            piso_load = 1'b1;
            piso_data = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && (repeat_cnt != '0)) begin
                        piso_load = 1'b1;
                        piso_data = pattern;
                    end
                end
                SHIFT: begin
                    if (piso_last && more_reps && (gap_lat == '0))
                        piso_load = 1'b1;
                    else
                        piso_shift = 1'b1;
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(1))
                        piso_load = 1'b1;
                end
                DONE: ;
            endcase
        end
    end

    seq_piso #(
        .PAT_W (PAT_W)
    ) u_piso (
        .clk        (clk),
        .reset      (reset),
        .load       (piso_load),
        .shift      (piso_shift),
        .data       (piso_data),
        .serial_bit (output_bit),
        .last_bit   (piso_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pat_lat     <= '0;
            rep_lat     <= '0;
            gap_lat     <= '0;
            gap_cnt     <= '0;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            reps_sent   <= '0;
        end else if (abort) begin
            state       <= IDLE;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pat_lat   <= pattern;
                        rep_lat   <= repeat_cnt;
                        gap_lat   <= gap_cycles;
                        reps_sent <= '0;
                        if (repeat_cnt != '0) begin
                            state       <= SHIFT;
                            bit_valid   <= 1'b1;
                            frame_start <= 1'b1;
                            busy        <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    frame_start <= 1'b0;
                    if (piso_last) begin
                        reps_sent <= (reps_sent == '1) ? reps_sent : reps_inc[CNT_W-1:0];
                        if (more_reps && (gap_lat == '0)) begin
                            frame_start <= 1'b1;
                        end else if (more_reps) begin
                            state     <= GAP;
                            gap_cnt   <= gap_lat;
                            bit_valid <= 1'b0;
                        end else begin
                            state     <= DONE;
                            bit_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(1)) begin
                        state       <= SHIFT;
                        bit_valid   <= 1'b1;
                        frame_start <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
